// File: rtl/fht_ctrl.sv
// Sequencer for an in-place radix-2 FHT engine: walks every stage through a
// full bank read sweep, waits out the butterfly pipeline, then advances.
module fht_ctrl #(
    parameter int ADDR_BIT   = 8,
    parameter int SEC_BIT    = 4,
    parameter int STG_BIT    = 4,
    parameter int LAST_STAGE = 9,
    parameter int PIPE_LAT   = 4,
    parameter int W_ADDR_BIT = 9
) (
    input  logic                  iCLK,
    input  logic                  iRESET,
    input  logic                  iSTART,
    output logic                  oBUSY,
    output logic                  oDONE,
    output logic [STG_BIT-1:0]    oSTAGE,
    output logic                  oST_ZERO,
    output logic                  oST_LAST,
    output logic                  o2ND_PART_SUBSECTOR,
    output logic [SEC_BIT-1:0]    oSECTOR,
    output logic [ADDR_BIT-1:0]   oRD_ADDR,
    output logic [ADDR_BIT-1:0]   oWR_ADDR,
    output logic                  oWR_EN,
    output logic [W_ADDR_BIT-1:0] oROM_ADDR
);
    typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_NEXT, S_DONE} state_t;

    typedef struct packed {
        logic                vld;
        logic                sub;
        logic [ADDR_BIT-1:0] addr;
    } wr_t;

    localparam logic [STG_BIT-1:0]  LAST_S     = STG_BIT'(LAST_STAGE);
    localparam logic [ADDR_BIT-1:0] RD_LAST    = '1;
    localparam logic [3:0]          DRAIN_INIT = 4'(PIPE_LAT - 1);
    localparam int                  PW         = PIPE_LAT * $bits(wr_t);

    state_t                  state;
    logic [STG_BIT-1:0]      stage;
    logic [ADDR_BIT-1:0]     rd_cnt;
    logic [3:0]              dcnt;
    logic                    busy, done, st_zero, st_last;
    logic [W_ADDR_BIT-1:0]   rom_addr;
    wr_t                     wr_in;
    wr_t [PIPE_LAT:1]        wr_pipe;

    // Twiddle index: butterfly number within its group, scaled to the ROM span.
    function automatic logic [W_ADDR_BIT-1:0] rom_fn(input logic [ADDR_BIT-1:0] rd,
                                                     input logic [STG_BIT-1:0]  stg);
        logic [31:0] idx;
        idx = 32'(rd >> 1) & ((32'd1 << stg) - 32'd1);
        idx = idx << (LAST_STAGE - 32'(stg));
        return idx[W_ADDR_BIT-1:0];
    endfunction

    // Bits beyond the address width shift out to zero, so no range guard needed.
    function automatic logic sub_fn(input logic [ADDR_BIT-1:0] rd,
                                    input logic [STG_BIT-1:0]  stg);
        logic [ADDR_BIT-1:0] t;
        t = rd >> (32'(stg) + 32'd1);
        return t[0];
    endfunction

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state    <= S_IDLE;
            stage    <= '0;
            rd_cnt   <= '0;
            dcnt     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            st_zero  <= 1'b0;
            st_last  <= 1'b0;
            rom_addr <= '0;
        end else begin
            case (state)
                S_IDLE: if (iSTART) begin
                    state   <= S_READ;
                    stage   <= '0;
                    rd_cnt  <= '0;
                    busy    <= 1'b1;
                    st_zero <= 1'b1;
                    st_last <= (LAST_S == '0);
                end
                S_READ: if (rd_cnt == RD_LAST) begin
                    state    <= S_DRAIN;
                    rd_cnt   <= '0;
                    dcnt     <= DRAIN_INIT;
                    rom_addr <= '0;
                end else begin
                    rd_cnt   <= rd_cnt + 1'b1;
                    rom_addr <= rom_fn(rd_cnt + 1'b1, stage);
                end
                // The last write of the stage leaves the pipe in the final drain cycle.
                S_DRAIN: if (dcnt == '0) begin
                    if (stage == LAST_S) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= S_NEXT;
                    end
                end else begin
                    dcnt <= dcnt - 1'b1;
                end
                S_NEXT: begin
                    state   <= S_READ;
                    stage   <= stage + 1'b1;
                    rd_cnt  <= '0;
                    st_zero <= 1'b0;
                    st_last <= ((stage + 1'b1) == LAST_S);
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    stage   <= '0;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    st_zero <= 1'b0;
                    st_last <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        wr_in      = '0;
        wr_in.vld  = (state == S_READ);
        wr_in.sub  = sub_fn(rd_cnt, stage);
        wr_in.addr = rd_cnt;
    end

    // Write side trails the read side by exactly the butterfly latency.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) wr_pipe <= '0;
        else         wr_pipe <= PW'({wr_pipe, wr_in});
    end

    assign oBUSY               = busy;
    assign oDONE               = done;
    assign oSTAGE              = stage;
    assign oST_ZERO            = st_zero;
    assign oST_LAST            = st_last;
    assign oSECTOR             = rd_cnt[ADDR_BIT-1 -: SEC_BIT];
    assign oRD_ADDR            = rd_cnt;
    assign oROM_ADDR           = rom_addr;
    assign oWR_EN              = wr_pipe[PIPE_LAT].vld;
    assign oWR_ADDR            = wr_pipe[PIPE_LAT].addr;
    assign o2ND_PART_SUBSECTOR = wr_pipe[PIPE_LAT].sub;
endmodule

// File: tb/tb_fht_ctrl.sv
// Scoreboard bench for fht_ctrl: each accepted start pushes the full expected
// cycle trace, computed from the stage schedule; a negedge monitor consumes it.
module tb_fht_ctrl;
    localparam int NR   = 256;          // reads per stage
    localparam int PL   = 4;            // butterfly latency
    localparam int LAST = 9;
    localparam int PER  = NR + PL + 1;  // cycles per stage
    localparam int NB   = (LAST + 1) * PER;

    typedef struct packed {
        logic       busy, done;
        logic [3:0] stage;
        logic       zero, last, sub;
        logic [3:0] sector;
        logic [7:0] rd, wr_addr;
        logic       wr_en;
        logic [8:0] rom;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t o;
    } item_t;

    logic       iCLK, iRESET, iSTART;
    logic       oBUSY, oDONE, oST_ZERO, oST_LAST, o2ND_PART_SUBSECTOR, oWR_EN;
    logic [3:0] oSTAGE, oSECTOR;
    logic [7:0] oRD_ADDR, oWR_ADDR;
    logic [8:0] oROM_ADDR;

    fht_ctrl dut (
        .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART),
        .oBUSY(oBUSY), .oDONE(oDONE), .oSTAGE(oSTAGE),
        .oST_ZERO(oST_ZERO), .oST_LAST(oST_LAST),
        .o2ND_PART_SUBSECTOR(o2ND_PART_SUBSECTOR), .oSECTOR(oSECTOR),
        .oRD_ADDR(oRD_ADDR), .oWR_ADDR(oWR_ADDR), .oWR_EN(oWR_EN),
        .oROM_ADDR(oROM_ADDR)
    );

    int    checks = 0, errors = 0, cyc = 0, next_ok = 0, runs = 0, last_e = 0;
    item_t sb[$];

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    always @(posedge iCLK) cyc <= cyc + 1;

    function automatic obs_t sample();
        obs_t a;
        a.busy = oBUSY;  a.done = oDONE;  a.stage = oSTAGE;
        a.zero = oST_ZERO;  a.last = oST_LAST;  a.sub = o2ND_PART_SUBSECTOR;
        a.sector = oSECTOR;  a.rd = oRD_ADDR;  a.wr_addr = oWR_ADDR;
        a.wr_en = oWR_EN;  a.rom = oROM_ADDR;
        return a;
    endfunction

    // Expected outputs for busy cycle k of a run, from the stage schedule.
    function automatic obs_t exp_at(int k);
        obs_t e;
        int   s, p, w;
        s = k / PER;
        p = k % PER;
        e = '0;
        e.busy    = 1'b1;
        e.done    = (s == LAST) && (p == PER - 1);
        e.stage   = 4'(s);
        e.zero    = (s == 0);
        e.last    = (s == LAST);
        e.rd      = (p < NR) ? 8'(p) : 8'd0;
        e.sector  = 4'(e.rd / 16);
        e.rom     = (p < NR) ? 9'((((p / 2) % (1 << s)) * (1 << (LAST - s))) % 512) : 9'd0;
        e.wr_en   = (p >= PL) && (p < NR + PL);
        w         = p - PL;
        e.wr_addr = e.wr_en ? 8'(w) : 8'd0;
        e.sub     = (e.wr_en && (s + 1 < 8)) ? (((w / (1 << (s + 1))) % 2) == 1) : 1'b0;
        return e;
    endfunction

    always @(negedge iCLK) begin
        obs_t  a, ex;
        item_t it;
        a  = sample();
        ex = '0;
        it.cyc = cyc;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            it = sb.pop_front();
            ex = it.o;
        end
        checks++;
        if (a !== ex) begin
            errors++;
            $display("FAIL trace cyc=%0d actual=%h required=%h", cyc, a, ex);
        end
    end

    // mode 0: hold iSTART low; 1: random iSTART; 2: force a start if idle.
    task automatic step(int mode);
        bit idle;
        @(negedge iCLK);
        #1;
        idle = (cyc + 1 >= next_ok);
        if (mode == 0)      iSTART = 1'b0;
        else if (mode == 2) iSTART = idle;
        else if (idle)      iSTART = ($urandom_range(0, 3) == 0);
        else                iSTART = ($urandom_range(0, 1) == 1);
        if (iSTART && idle && iRESET) begin
            last_e = cyc + 1;
            for (int k = 0; k < NB; k++) begin
                item_t it;
                it.cyc = last_e + k;
                it.o   = exp_at(k);
                sb.push_back(it);
            end
            next_ok = last_e + NB + 1;
            runs++;
        end
    endtask

    task automatic random_runs(int target);
        for (int i = 0; i < 9000 && !(runs >= target && cyc + 1 >= next_ok + 3); i++)
            step(1);
    endtask

    initial begin
        obs_t a;
        iRESET = 1'b0;
        iSTART = 1'b0;
        repeat (3) @(negedge iCLK);
        #1 iRESET = 1'b1;
        repeat (20) step(0);

        // Two runs with iSTART toggling randomly throughout, including while busy.
        random_runs(2);

        // Asynchronous abort in stage 3 at read address 100.
        for (int i = 0; i < 4000 && runs < 3; i++) step(2);
        for (int i = 0; i < 4000 && cyc < last_e + 3 * PER + 100; i++) step(1);
        iRESET = 1'b0;
        iSTART = 1'b0;
        #1;
        a = sample();
        checks++;
        if (a !== '0) begin
            errors++;
            $display("FAIL reset_async actual=%h required=0", a);
        end
        sb.delete();
        next_ok = 0;
        @(negedge iCLK);
        #1 iRESET = 1'b1;

        // Restart after the abort must begin cleanly at stage 0.
        random_runs(4);
        repeat (5) step(0);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover actual=%0d required=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fht_ctrl.md
FHT_CTRL -- requirements
Module: fht_ctrl

Interface
REQ-001 Parameter ADDR_BIT, default 8, per-bank RAM address width; 2^ADDR_BIT reads per stage.
REQ-002 Parameter SEC_BIT, default 4, sector field width.
REQ-003 Parameter STG_BIT, default 4, stage counter width.
REQ-004 Parameter LAST_STAGE, default 9, index of final stage; stages run 0..LAST_STAGE.
REQ-005 Parameter PIPE_LAT, default 4, butterfly-block read-to-write latency in cycles; range 1..15.
REQ-006 Parameter W_ADDR_BIT, default 9, twiddle ROM address width.
REQ-007 iCLK  in  1  clock; all state updates on rising edge.
REQ-008 iRESET  in  1  asynchronous, active-low reset.
REQ-009 iSTART  in  1  start request, sampled only in IDLE.
REQ-010 oBUSY  out  1  high in every state except IDLE.
REQ-011 oDONE  out  1  one-cycle completion pulse.
REQ-012 oSTAGE  out  STG_BIT  current stage index.
REQ-013 oST_ZERO  out  1  high while oSTAGE==0 and not IDLE.
REQ-014 oST_LAST  out  1  high while oSTAGE==LAST_STAGE and not IDLE.
REQ-015 o2ND_PART_SUBSECTOR  out  1  subsector-half select to butterfly output mixer.
REQ-016 oSECTOR  out  SEC_BIT  sector select to butterfly input mixers.
REQ-017 oRD_ADDR  out  ADDR_BIT  bank read address.
REQ-018 oWR_ADDR  out  ADDR_BIT  bank write address.
REQ-019 oWR_EN  out  1  bank write enable.
REQ-020 oROM_ADDR  out  W_ADDR_BIT  twiddle ROM address (sin/cos for both butterflies).

Function
REQ-021 FSM states IDLE, READ, DRAIN, NEXT, DONE; all outputs registered.
REQ-022 IDLE: iSTART=1 -> READ, stage=0, rd_cnt=0; otherwise stay.
REQ-023 READ: oRD_ADDR=rd_cnt; rd_cnt increments each cycle; after rd_cnt==2^ADDR_BIT-1 -> DRAIN, rd_cnt wraps to 0.
REQ-024 DRAIN: no reads; lasts exactly PIPE_LAT cycles (own down-counter); then -> DONE if stage==LAST_STAGE, else -> NEXT.
REQ-025 NEXT: one cycle, stage increments, -> READ with rd_cnt=0.
REQ-026 DONE: oDONE=1 for this single cycle, -> IDLE.
REQ-027 Two consecutive READ cycles form one double-butterfly op: rd_cnt[0]=0 fetches X2/X3, rd_cnt[0]=1 fetches X1.
REQ-028 oSECTOR = rd_cnt[ADDR_BIT-1 : ADDR_BIT-SEC_BIT] during READ, 0 otherwise.
REQ-029 o2ND_PART_SUBSECTOR = rd_cnt[stage+1] when stage+1<ADDR_BIT, else 0; delayed PIPE_LAT cycles to align with butterfly output.
REQ-030 oROM_ADDR = ((rd_cnt>>1) masked to low `stage` bits) << (LAST_STAGE-stage), truncated to W_ADDR_BIT; 0 when stage==0.
REQ-031 oWR_EN = (state==READ) delayed PIPE_LAT cycles; oWR_ADDR = oRD_ADDR delayed PIPE_LAT cycles via shift register.
REQ-032 Last write of a stage occurs in final DRAIN cycle; first read of next stage never precedes it (no RAW hazard).
REQ-033 iSTART while oBUSY=1 ignored; iSTART during DONE ignored.
REQ-034 Cycle budget: per stage 2^ADDR_BIT + PIPE_LAT + 1 cycles.

Reset
REQ-035 iRESET=0 forces IDLE immediately: all outputs, counters, delay lines to 0 regardless of state.
REQ-036 Reset mid-operation discards in-flight writes; oWR_EN stays 0 until a new stage reads plus PIPE_LAT.

Verification
REQ-037 Reset release, iSTART=0 for 20 cycles -> all outputs 0, oBUSY=0.
REQ-038 iSTART pulse (defaults) -> oRD_ADDR 0..255 consecutive, oST_ZERO=1, oROM_ADDR=0; oWR_EN rises 4 cycles after first read, oWR_ADDR=0.
REQ-039 Stage 0->1 boundary -> 4 DRAIN cycles with oWR_EN=1, oWR_ADDR 252..255, one NEXT cycle, then oSTAGE=1, oRD_ADDR=0.
REQ-040 Full run -> oST_LAST=1 only in stage 9; oDONE single pulse exactly 2610 cycles after iSTART sampled; oBUSY falls next cycle.
REQ-041 iSTART asserted repeatedly while busy -> no restart, completion cycle unchanged.
REQ-042 iRESET asserted in stage 3 READ at rd_cnt=100 -> outputs 0 same cycle; new iSTART restarts at stage 0, rd_cnt 0.
